instruction_fetch: RTL

//  Front-end stage upstream of branch resolution: owns the fetch PC, issues instruction-memory reads,

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/instruction_fetch_fifo.sv | 62 ++++++
 rtl/instruction_fetch.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction fetch front-end.
// Latency: none (types, constants and a pure helper only).
// Backpressure: not applicable.
package riscv_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // A fetch target must be word aligned
  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Instruction buffer: registered FIFO of {pc, instr} entries with flush.
// Latency: push in cycle N is visible at the head in cycle N+1 (no bypass).
// Backpressure: none internally; the writer guarantees space, flush beats push/pop.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign head    = mem[rd_ptr];

  // Storage: cleared on reset so the head reads as zero until the first push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties the buffer in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
      assert (!(do_push && !do_pop && count == FULL_CNT));
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues imem reads, buffers words, presents {pc, instr} to decode.
// Latency: imem response in cycle N -> dec_valid in cycle N+1; redirect in N -> new request in N+1.
// Backpressure: dec_ready low fills the buffer; requests stop via credits (buffer + in-flight <= depth).
// Optional: define IFETCH_PERF_EN to add perf_fetched / perf_squashed saturating counters.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_VECTOR,
  parameter int          FIFO_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
`ifdef IFETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed,
`endif
  output logic        fetch_fault
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [SW-1:0] DEPTH_S = SW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_O   = CW'(MAX_OUTST);

  fetch_state_e  state;
  logic          started;
  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] outst;
  logic [CW-1:0] outst_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] fifo_cnt;
  logic          credit_ok;
  logic          req_hs;
  logic          keep_rsp;
  logic          drop_rsp;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  fifo_head;

  // Buffered words plus reads still in flight may never exceed the buffer size
  assign credit_ok = (({1'b0, fifo_cnt} + {1'b0, outst}) < DEPTH_S) && (outst < MAX_O);

  // started holds requests off for the first cycle after reset release
  assign imem_req_valid = started && (state == RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;

  // A response arriving in the redirect cycle is stale, so it is dropped without counting in drop
  assign outst_next = outst + CW'(req_hs) - CW'(imem_rsp_valid);
  assign keep_rsp   = imem_rsp_valid && !redirect_valid && (drop == '0);
  assign drop_rsp   = imem_rsp_valid && (redirect_valid || (drop != '0));

  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  assign dec_valid = (fifo_cnt != '0) && (state == RUN) && !redirect_valid;
  assign pop       = dec_valid && dec_ready;
  assign dec_pc    = fifo_head.pc;
  assign dec_instr = fifo_head.instr;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (keep_rsp),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  // Run/fault control: misaligned redirect parks the stage, an aligned one releases it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      fetch_fault <= 1'b0;
      started     <= 1'b0;
    end else begin
      started <= 1'b1;
      case (state)
        RUN: begin
          if (redirect_valid && misaligned(redirect_pc)) begin
            state       <= FAULT;
            fetch_fault <= 1'b1;
          end
        end
        FAULT: begin
          if (redirect_valid && !misaligned(redirect_pc)) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // PCs and in-flight bookkeeping; every read still outstanding after a redirect is stale
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      outst <= outst_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop     <= outst_next;
      end else begin
        if (req_hs)   fetch_pc <= fetch_pc + 32'd4;
        if (keep_rsp) rsp_pc   <= rsp_pc + 32'd4;
        if (drop_rsp) drop     <= drop - CW'(1);
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [SW-1:0] squash_now;
  logic [32:0]   fetched_sum;
  logic [32:0]   squashed_sum;

  assign squash_now   = (redirect_valid ? {1'b0, fifo_cnt} : '0) + SW'(drop_rsp);
  assign fetched_sum  = {1'b0, perf_fetched} + 33'(keep_rsp);
  assign squashed_sum = {1'b0, perf_squashed} + 33'(squash_now);

  // Saturating event counters: words buffered, and words discarded by flush or drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= fetched_sum[32]  ? '1 : fetched_sum[31:0];
      perf_squashed <= squashed_sum[32] ? '1 : squashed_sum[31:0];
    end
  end
`endif

endmodule
